// File: rtl/chunk_buf_pkg.sv
// Shared types and default geometry for the chunk ping-pong receive buffer.
package chunk_buf_pkg;

  localparam int unsigned DEF_BUS_SIZE       = 4;
  localparam int unsigned DEF_WR_DAT_CYC_NUM = 6;
  localparam int unsigned DEF_DATA_W         = 8;

  localparam int unsigned BEAT_IDX_W = $clog2(DEF_WR_DAT_CYC_NUM);
  localparam int unsigned BEAT_W     = DEF_BUS_SIZE + DEF_BUS_SIZE * DEF_DATA_W;

  typedef logic bank_sel_t;

  typedef struct packed {
    logic [DEF_BUS_SIZE-1:0]                 smap;
    logic [DEF_BUS_SIZE-1:0][DEF_DATA_W-1:0] nz;
  } beat_t;

endpackage

// File: rtl/chunk_bank.sv
// One bank of the ping-pong buffer: DEPTH x WIDTH register file with a
// synchronous write port and a registered read port.
module chunk_bank #(
  parameter  int unsigned DEPTH  = 6,
  parameter  int unsigned WIDTH  = 36,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  // Address range guards; indices past DEPTH never touch the array.
  always_comb begin
    wr_ok = wr_en_i && ({1'b0, wr_addr_i} < DEPTH_L);
    rd_ok = ({1'b0, rd_addr_i} < DEPTH_L);
  end

  // Storage array: contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port, cleared by reset so outputs start at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else if (rd_ok) begin
      rd_data_o <= mem[rd_addr_i];
    end else begin
      rd_data_o <= '0;
    end
  end

endmodule

// File: rtl/chunk_pingpong_rx.sv
// Receive side of the chunk-write interface: captures SRAM read beats into
// a two-bank ping-pong buffer while the compute unit reads the other bank.
module chunk_pingpong_rx #(
  parameter  int unsigned BUS_SIZE       = chunk_buf_pkg::DEF_BUS_SIZE,
  parameter  int unsigned WR_DAT_CYC_NUM = chunk_buf_pkg::DEF_WR_DAT_CYC_NUM,
  parameter  int unsigned DATA_W         = chunk_buf_pkg::DEF_DATA_W,
  localparam int unsigned IDX_W          = $clog2(WR_DAT_CYC_NUM)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       chunk_wr_valid_i,
  input  logic [IDX_W-1:0]           chunk_wr_count_i,
  input  logic                       chunk_wr_sel_i,
  input  logic                       chunk_rd_sel_i,
  input  logic [BUS_SIZE-1:0]        sram_sparsemap_i,
  input  logic [BUS_SIZE*DATA_W-1:0] sram_nonzero_i,
  input  logic [IDX_W-1:0]           rd_beat_i,
  output logic [BUS_SIZE-1:0]        rd_sparsemap_o,
  output logic [BUS_SIZE*DATA_W-1:0] rd_nonzero_o,
  output logic                       rd_valid_o,
  output logic [IDX_W-1:0]           rd_last_beat_o,
  output logic [1:0]                 bank_full_o,
  output logic                       chunk_done_o,
  output logic                       err_o
);

  import chunk_buf_pkg::*;

  localparam int unsigned LEN_W   = $clog2(WR_DAT_CYC_NUM + 1);
  localparam int unsigned NZ_W    = BUS_SIZE * DATA_W;
  localparam int unsigned WORD_W  = BUS_SIZE + NZ_W;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(WR_DAT_CYC_NUM);

  // S1 request stage and the delayed copy used for chunk edge detection
  logic             s1_vld;
  logic [IDX_W-1:0] s1_cnt;
  bank_sel_t        s1_sel;
  logic             s2_vld;
  bank_sel_t        s2_sel;

  logic [1:0]            bank_full;
  logic [1:0][LEN_W-1:0] bank_len;
  logic                  err_q;
  logic                  done_q;

  logic             wr_in_range;
  logic             wr_en;
  logic [1:0]       bank_wr_en;
  logic             wr_conflict;
  logic             chunk_start;
  logic             chunk_end;
  logic [LEN_W-1:0] len_next;

  logic [LEN_W-1:0] rd_len;
  logic             rd_hit;
  logic [IDX_W-1:0] rd_last;
  bank_sel_t        rd_sel_q;
  logic             rd_valid_q;
  logic [IDX_W-1:0] rd_last_q;

  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] bank_rd_data [2];
  logic [WORD_W-1:0] rd_word;

  // Write-side decode. A sel change while valid stays high counts as both
  // the end of the old chunk and the start of a new one.
  always_comb begin
    wr_in_range   = ({1'b0, s1_cnt} < DEPTH_L);
    wr_en         = s1_vld && wr_in_range;
    bank_wr_en[0] = wr_en && (s1_sel == 1'b0);
    bank_wr_en[1] = wr_en && (s1_sel == 1'b1);
    wr_conflict   = s1_vld && (s1_sel == chunk_rd_sel_i);
    chunk_start   = s1_vld && (!s2_vld || (s1_sel != s2_sel));
    chunk_end     = s2_vld && (!s1_vld || (s1_sel != s2_sel));
    len_next      = LEN_W'({1'b0, s1_cnt}) + LEN_W'(1);
    wr_word       = {sram_sparsemap_i, sram_nonzero_i};
  end

  // S1 capture of the request and S2 history for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld <= 1'b0;
      s1_cnt <= '0;
      s1_sel <= 1'b0;
      s2_vld <= 1'b0;
      s2_sel <= 1'b0;
    end else begin
      s1_vld <= chunk_wr_valid_i;
      s1_cnt <= chunk_wr_count_i;
      s1_sel <= chunk_wr_sel_i;
      s2_vld <= s1_vld;
      s2_sel <= s1_sel;
    end
  end

  // Per-bank completion flag and stored length; start and end of
  // back-to-back chunks land on different banks so both updates apply.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_full <= '0;
      bank_len  <= '0;
    end else begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (chunk_end && (s2_sel == bank_sel_t'(b))) begin
          bank_full[b] <= 1'b1;
        end
        if (chunk_start && (s1_sel == bank_sel_t'(b))) begin
          bank_full[b] <= 1'b0;
        end
        if (bank_wr_en[b]) begin
          bank_len[b] <= len_next;
        end
      end
    end
  end

  // Completion pulse and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= chunk_end;
      if ((s1_vld && !wr_in_range) || wr_conflict) begin
        err_q <= 1'b1;
      end
    end
  end

  chunk_bank #(
    .DEPTH (WR_DAT_CYC_NUM),
    .WIDTH (WORD_W)
  ) u_bank0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (bank_wr_en[0]),
    .wr_addr_i (s1_cnt),
    .wr_data_i (wr_word),
    .rd_addr_i (rd_beat_i),
    .rd_data_o (bank_rd_data[0])
  );

  chunk_bank #(
    .DEPTH (WR_DAT_CYC_NUM),
    .WIDTH (WORD_W)
  ) u_bank1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (bank_wr_en[1]),
    .wr_addr_i (s1_cnt),
    .wr_data_i (wr_word),
    .rd_addr_i (rd_beat_i),
    .rd_data_o (bank_rd_data[1])
  );

  // Read-side qualification against the selected bank's state
  always_comb begin
    rd_len  = bank_len[chunk_rd_sel_i];
    rd_hit  = bank_full[chunk_rd_sel_i] &&
              ((LEN_W+1)'(rd_beat_i) < {1'b0, rd_len});
    rd_last = '0;
    if (rd_len != '0) begin
      rd_last = IDX_W'(rd_len - LEN_W'(1));
    end
  end

  // Both banks are read every cycle; the registered select picks one, so
  // data, valid and last-beat all share the same one-cycle latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_sel_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= '0;
    end else begin
      rd_sel_q   <= chunk_rd_sel_i;
      rd_valid_q <= rd_hit;
      rd_last_q  <= rd_last;
    end
  end

  // Output mapping
  always_comb begin
    rd_word        = bank_rd_data[rd_sel_q];
    rd_sparsemap_o = rd_word[WORD_W-1 -: BUS_SIZE];
    rd_nonzero_o   = rd_word[NZ_W-1:0];
    rd_valid_o     = rd_valid_q;
    rd_last_beat_o = rd_last_q;
    bank_full_o    = bank_full;
    chunk_done_o   = done_q;
    err_o          = err_q;
  end

endmodule

// File: tb/tb_chunk_pingpong_rx.sv
// Self-checking bench for chunk_pingpong_rx with a transaction-level model.
module tb_chunk_pingpong_rx;
  import chunk_buf_pkg::*;

  localparam int unsigned BS  = DEF_BUS_SIZE;
  localparam int unsigned N   = DEF_WR_DAT_CYC_NUM;
  localparam int unsigned DW  = DEF_DATA_W;
  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned NZW = BS * DW;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           chunk_wr_valid_i;
  logic [IW-1:0]  chunk_wr_count_i;
  logic           chunk_wr_sel_i;
  logic           chunk_rd_sel_i;
  logic [BS-1:0]  sram_sparsemap_i;
  logic [NZW-1:0] sram_nonzero_i;
  logic [IW-1:0]  rd_beat_i;
  logic [BS-1:0]  rd_sparsemap_o;
  logic [NZW-1:0] rd_nonzero_o;
  logic           rd_valid_o;
  logic [IW-1:0]  rd_last_beat_o;
  logic [1:0]     bank_full_o;
  logic           chunk_done_o;
  logic           err_o;

  chunk_pingpong_rx #(
    .BUS_SIZE       (BS),
    .WR_DAT_CYC_NUM (N),
    .DATA_W         (DW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .chunk_wr_valid_i (chunk_wr_valid_i),
    .chunk_wr_count_i (chunk_wr_count_i),
    .chunk_wr_sel_i   (chunk_wr_sel_i),
    .chunk_rd_sel_i   (chunk_rd_sel_i),
    .sram_sparsemap_i (sram_sparsemap_i),
    .sram_nonzero_i   (sram_nonzero_i),
    .rd_beat_i        (rd_beat_i),
    .rd_sparsemap_o   (rd_sparsemap_o),
    .rd_nonzero_o     (rd_nonzero_o),
    .rd_valid_o       (rd_valid_o),
    .rd_last_beat_o   (rd_last_beat_o),
    .bank_full_o      (bank_full_o),
    .chunk_done_o     (chunk_done_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: bank contents, lengths, completion flags, sticky error
  logic [BS-1:0]  m_smap [2][N];
  logic [NZW-1:0] m_nz   [2][N];
  int             m_len  [2];
  logic           m_full [2];
  logic           m_err;

  int pass_cnt = 0;
  int total    = 0;

  task automatic model_reset();
    m_len[0] = 0; m_len[1] = 0;
    m_full[0] = 1'b0; m_full[1] = 1'b0;
    m_err = 1'b0;
  endtask

  // Load one chunk; beat number oor_at (if >= 0) uses count N (out of range).
  task automatic load_chunk(input bit sel, input int n, input int oor_at,
                            input bit watch_rd, input bit conflict);
    int             cnt_q [$];
    logic [BS-1:0]  sm_q  [$];
    logic [NZW-1:0] nz_q  [$];
    int             done_at;
    int             done_cnt;
    logic           rd_exp;
    rd_exp = m_full[chunk_rd_sel_i] && (int'(rd_beat_i) < m_len[chunk_rd_sel_i]);
    for (int i = 0; i < n; i++) begin
      cnt_q.push_back((i == oor_at) ? int'(N) : i);
      sm_q.push_back(BS'($urandom));
      nz_q.push_back(NZW'($urandom));
    end
    done_at  = -1;
    done_cnt = 0;
    for (int c = 0; c < n + 6; c++) begin
      @(negedge clk_i);
      if (chunk_done_o) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == 2 && n >= 2) begin
        total++;
        if (bank_full_o[sel] !== 1'b0)
          $display("FAIL full_clear_on_first_write: got %b expected 0", bank_full_o[sel]);
        else pass_cnt++;
      end
      if (watch_rd && c > 0) begin
        total++;
        if (rd_valid_o !== rd_exp)
          $display("FAIL rd_valid_other_bank c=%0d: got %b expected %b", c, rd_valid_o, rd_exp);
        else pass_cnt++;
      end
      if (conflict && c == 1) begin
        total++;
        if (err_o !== 1'b0) $display("FAIL conflict_err_early: got %b expected 0", err_o);
        else pass_cnt++;
      end
      if (conflict && c == 2) begin
        total++;
        if (err_o !== 1'b1) $display("FAIL conflict_err: got %b expected 1", err_o);
        else pass_cnt++;
      end
      if (conflict && c == 3) begin
        total++;
        if (rd_valid_o !== 1'b0) $display("FAIL conflict_rd_valid_drop: got %b expected 0", rd_valid_o);
        else pass_cnt++;
      end
      if (c < n) begin
        chunk_wr_valid_i = 1'b1;
        chunk_wr_count_i = IW'(cnt_q[c]);
        chunk_wr_sel_i   = sel;
      end else begin
        chunk_wr_valid_i = 1'b0;
        chunk_wr_count_i = IW'($urandom);
      end
      if (c >= 1 && c <= n) begin
        sram_sparsemap_i = sm_q[c-1];
        sram_nonzero_i   = nz_q[c-1];
      end else begin
        sram_sparsemap_i = BS'($urandom);
        sram_nonzero_i   = NZW'($urandom);
      end
    end
    // Transaction-level model update
    for (int i = 0; i < n; i++) begin
      if (cnt_q[i] < int'(N)) begin
        m_smap[sel][cnt_q[i]] = sm_q[i];
        m_nz[sel][cnt_q[i]]   = nz_q[i];
        m_len[sel]            = cnt_q[i] + 1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (sel == chunk_rd_sel_i) m_err = 1'b1;
    m_full[sel] = 1'b1;
    total++;
    if (done_at !== n + 2 || done_cnt !== 1)
      $display("FAIL chunk_done_timing: got at=%0d count=%0d expected at=%0d count=1",
               done_at, done_cnt, n + 2);
    else pass_cnt++;
    total++;
    if (bank_full_o !== {m_full[1], m_full[0]})
      $display("FAIL bank_full_after_load: got %b expected %b", bank_full_o, {m_full[1], m_full[0]});
    else pass_cnt++;
    total++;
    if (err_o !== m_err) $display("FAIL err_after_load: got %b expected %b", err_o, m_err);
    else pass_cnt++;
  endtask

  task automatic read_check(input bit sel, input int beat);
    logic exp_v;
    @(negedge clk_i);
    chunk_rd_sel_i = sel;
    rd_beat_i      = IW'(beat);
    @(negedge clk_i);
    exp_v = m_full[sel] && (beat < m_len[sel]);
    total++;
    if (rd_valid_o !== exp_v)
      $display("FAIL rd_valid bank%0d beat%0d: got %b expected %b", sel, beat, rd_valid_o, exp_v);
    else pass_cnt++;
    if (exp_v) begin
      total++;
      if (rd_sparsemap_o !== m_smap[sel][beat] || rd_nonzero_o !== m_nz[sel][beat])
        $display("FAIL rd_data bank%0d beat%0d: got %h_%h expected %h_%h", sel, beat,
                 rd_sparsemap_o, rd_nonzero_o, m_smap[sel][beat], m_nz[sel][beat]);
      else pass_cnt++;
    end
    if (m_len[sel] > 0) begin
      total++;
      if (int'(rd_last_beat_o) !== m_len[sel] - 1)
        $display("FAIL rd_last_beat bank%0d: got %0d expected %0d", sel, rd_last_beat_o, m_len[sel] - 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    chunk_wr_valid_i = 1'b0; chunk_wr_count_i = '0; chunk_wr_sel_i = 1'b0;
    chunk_rd_sel_i = 1'b0; rd_beat_i = '0;
    sram_sparsemap_i = '0; sram_nonzero_i = '0;
    model_reset();
    repeat (3) @(negedge clk_i);
    total++;
    if ({rd_valid_o, bank_full_o, chunk_done_o, err_o} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {rd_valid_o, bank_full_o, chunk_done_o, err_o});
    else pass_cnt++;
    total++;
    if (rd_sparsemap_o !== '0 || rd_nonzero_o !== '0 || rd_last_beat_o !== '0)
      $display("FAIL reset_rd_data: got %h_%h_%h expected 0", rd_sparsemap_o, rd_nonzero_o, rd_last_beat_o);
    else pass_cnt++;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_single_load();
    chunk_rd_sel_i = 1'b0;
    load_chunk(1'b1, 4, -1, 1'b0, 1'b0);
    total++;
    if (bank_full_o !== 2'b10) $display("FAIL single_bank_full: got %b expected 10", bank_full_o);
    else pass_cnt++;
    for (int b = 0; b < 4; b++) read_check(1'b1, b);
    read_check(1'b1, 4);
  endtask

  task automatic test_pingpong();
    @(negedge clk_i);
    chunk_rd_sel_i = 1'b1;
    rd_beat_i      = 2'd2;
    @(negedge clk_i);
    load_chunk(1'b0, 2, -1, 1'b1, 1'b0);
    total++;
    if (bank_full_o !== 2'b11) $display("FAIL pingpong_bank_full: got %b expected 11", bank_full_o);
    else pass_cnt++;
    for (int b = 0; b < 4; b++) read_check(1'b1, b);
    for (int b = 0; b < 3; b++) read_check(1'b0, b);
  endtask

  task automatic test_reload();
    int n;
    n = int'($urandom_range(2, N));
    @(negedge clk_i);
    chunk_rd_sel_i = 1'b0;
    load_chunk(1'b1, n, -1, 1'b0, 1'b0);
    for (int b = 0; b < int'(N); b++) read_check(1'b1, b);
  endtask

  task automatic test_out_of_range();
    @(negedge clk_i);
    chunk_rd_sel_i = 1'b1;
    load_chunk(1'b0, 4, 3, 1'b0, 1'b0);
    total++;
    if (err_o !== 1'b1) $display("FAIL oor_err: got %b expected 1", err_o);
    else pass_cnt++;
    for (int b = 0; b < 4; b++) read_check(1'b0, b);
  endtask

  task automatic test_reset_mid_chunk();
    int dones;
    @(negedge clk_i);
    chunk_rd_sel_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chunk_wr_valid_i = 1'b1;
      chunk_wr_count_i = IW'(c);
      chunk_wr_sel_i   = 1'b0;
      sram_sparsemap_i = BS'($urandom);
      sram_nonzero_i   = NZW'($urandom);
      @(negedge clk_i);
    end
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    total++;
    if ({rd_valid_o, bank_full_o, chunk_done_o, err_o} !== 5'b0 || rd_nonzero_o !== '0)
      $display("FAIL async_reset_outputs: got %b_%h expected 0",
               {rd_valid_o, bank_full_o, chunk_done_o, err_o}, rd_nonzero_o);
    else pass_cnt++;
    @(negedge clk_i);
    chunk_wr_valid_i = 1'b0;
    rst_i = 1'b0;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (chunk_done_o) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL no_done_after_reset: got %0d pulses expected 0", dones);
    else pass_cnt++;
    total++;
    if (bank_full_o !== 2'b00 || err_o !== 1'b0)
      $display("FAIL state_after_reset: got full=%b err=%b expected 00/0", bank_full_o, err_o);
    else pass_cnt++;
    load_chunk(1'b0, 4, -1, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) read_check(1'b0, b);
  endtask

  task automatic test_conflict();
    read_check(1'b0, 0);
    load_chunk(1'b0, 3, -1, 1'b0, 1'b1);
    for (int b = 0; b < 4; b++) read_check(1'b0, b);
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_pingpong();
    test_reload();
    test_out_of_range();
    test_reset_mid_chunk();
    test_conflict();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
